// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the tx_framer serial framer.
package tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is treated the same as PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_parity_calc.sv
// Combinational parity bit generator: even, odd or none (forced 0).
module tx_parity_calc
  import tx_framer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  output logic              parity_o
);

  always_comb begin
    parity_o = 1'b0;
    case (mode_i)
      PAR_EVEN: parity_o = ^data_i;
      PAR_ODD:  parity_o = ~(^data_i);
      default:  parity_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tx_framer.sv
// Serial frame transmitter: start, DATA_W bits LSB first, optional parity, stop bits.
// Optional parallel frame snapshot output o_Frame when TX_FRAMER_FRAME_OUT_EN is defined.
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_BaudTick,
  input  logic [1:0]        i_Parity,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic              o_Tx,
  output logic              o_Busy,
  output logic              o_Done
`ifdef TX_FRAMER_FRAME_OUT_EN
  ,
  output logic [DATA_W+2+STOP_BITS-1:0] o_Frame
`endif
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS == 2);

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0]   shift_q,   shift_d;
  logic                par_bit_q, par_bit_d;
  logic                par_en_q,  par_en_d;
  logic                tx_q,      tx_d;
  logic                done_q,    done_d;
  logic                accept;
  logic                par_calc;

  assign accept = i_Valid && (state_q == ST_IDLE);

  tx_parity_calc #(
    .DATA_W(DATA_W)
  ) u_parity (
    .data_i  (i_Data),
    .mode_i  (i_Parity),
    .parity_o(par_calc)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A tick on the accept edge is deliberately ignored here.
        if (accept) begin
          state_d   = ST_START;
          shift_d   = i_Data;
          par_bit_d = par_calc;
          par_en_d  = parity_enabled(i_Parity);
        end
      end
      ST_START: begin
        if (i_BaudTick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (i_BaudTick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (i_BaudTick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (i_BaudTick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the next state so o_Tx is a clean register output.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_Ready = (state_q == ST_IDLE);
  assign o_Busy  = ~o_Ready;
  assign o_Tx    = tx_q;
  assign o_Done  = done_q;

`ifdef TX_FRAMER_FRAME_OUT_EN
  localparam int FRAME_W = DATA_W + 2 + STOP_BITS;
  localparam logic [FRAME_W-1:0] FRAME_RST = {{(DATA_W + 2){1'b0}}, {STOP_BITS{1'b1}}};

  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (accept) begin
      frame_d = {1'b0, i_Data, par_calc, {STOP_BITS{1'b1}}};
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_q <= FRAME_RST;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign o_Frame = frame_q;
`endif

endmodule

// File: tb/tb_tx_framer.sv
// Directed self-checking bench for tx_framer (three parameter sets, optional o_Frame).
module tb_tx_framer;
  import tx_framer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] par = PAR_NONE;
  logic [7:0] data8 = 8'h00;
  logic [4:0] data5 = 5'h00;
  logic       v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic       r1, t1, b1, d1;
  logic       r2, t2, b2, d2;
  logic       r3, t3, b3, d3;
`ifdef TX_FRAMER_FRAME_OUT_EN
  logic [10:0] f1;
  logic [11:0] f2;
  logic [8:0]  f3;
`endif

  int checks = 0;
  int errors = 0;

  logic cap_tx   [0:63];
  logic cap_done [0:63];
  logic cap_rdy  [0:63];

  always #5 clk = ~clk;

  tx_framer #(.DATA_W(8), .STOP_BITS(1)) u1 (
    .i_Pclk(clk), .i_Rst(rst), .i_BaudTick(tick), .i_Parity(par), .i_Data(data8),
    .i_Valid(v1), .o_Ready(r1), .o_Tx(t1), .o_Busy(b1), .o_Done(d1)
`ifdef TX_FRAMER_FRAME_OUT_EN
    , .o_Frame(f1)
`endif
  );

  tx_framer #(.DATA_W(8), .STOP_BITS(2)) u2 (
    .i_Pclk(clk), .i_Rst(rst), .i_BaudTick(tick), .i_Parity(par), .i_Data(data8),
    .i_Valid(v2), .o_Ready(r2), .o_Tx(t2), .o_Busy(b2), .o_Done(d2)
`ifdef TX_FRAMER_FRAME_OUT_EN
    , .o_Frame(f2)
`endif
  );

  tx_framer #(.DATA_W(5), .STOP_BITS(1)) u3 (
    .i_Pclk(clk), .i_Rst(rst), .i_BaudTick(tick), .i_Parity(par), .i_Data(data5),
    .i_Valid(v3), .o_Ready(r3), .o_Tx(t3), .o_Busy(b3), .o_Done(d3)
`ifdef TX_FRAMER_FRAME_OUT_EN
    , .o_Frame(f3)
`endif
  );

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel, input int k);
    case (sel)
      1:       begin cap_tx[k] = t1; cap_done[k] = d1; cap_rdy[k] = r1; end
      2:       begin cap_tx[k] = t2; cap_done[k] = d2; cap_rdy[k] = r2; end
      default: begin cap_tx[k] = t3; cap_done[k] = d3; cap_rdy[k] = r3; end
    endcase
  endtask

  // Offer one word, then tick every 4 clocks counted from the accept edge.
  task automatic capture(input int sel, input logic [7:0] d, input logic [1:0] p,
                         input logic acc_tick, input int n);
    data8 = d;
    data5 = d[4:0];
    par   = p;
    tick  = acc_tick;
    case (sel)
      1:       v1 = 1'b1;
      2:       v2 = 1'b1;
      default: v3 = 1'b1;
    endcase
    step();
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    tick = 1'b0;
    sample(sel, 0);
    for (int k = 1; k <= n; k++) begin
      tick = ((k % 4) == 0);
      step();
      sample(sel, k);
    end
    tick = 1'b0;
    $display("frame dut=%0d data=%h parity_mode=%b tick_on_accept=%b", sel, d, p, acc_tick);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (t1 !== 1'b1 || t2 !== 1'b1 || t3 !== 1'b1) begin errors++; $display("FAIL reset_tx got %b%b%b exp 111", t1, t2, t3); end
    checks++; if (r1 !== 1'b1 || r2 !== 1'b1 || r3 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b%b exp 111", r1, r2, r3); end
    checks++; if (b1 !== 1'b0 || b2 !== 1'b0 || b3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b%b exp 000", b1, b2, b3); end
    checks++; if (d1 !== 1'b0 || d2 !== 1'b0 || d3 !== 1'b0) begin errors++; $display("FAIL reset_done got %b%b%b exp 000", d1, d2, d3); end
`ifdef TX_FRAMER_FRAME_OUT_EN
    checks++; if (f1 !== 11'b000_0000_0001) begin errors++; $display("FAIL reset_frame1 got %b exp 00000000001", f1); end
    checks++; if (f2 !== 12'b0000_0000_0011) begin errors++; $display("FAIL reset_frame2 got %b exp 000000000011", f2); end
    checks++; if (f3 !== 9'b0_0000_0001) begin errors++; $display("FAIL reset_frame3 got %b exp 000000001", f3); end
`endif
    rst = 1'b0;
    $display("reset applied and released");
  endtask

  task automatic test_frame_even_a5();
    logic [0:10] e;
    e = 11'b01010010101;
    capture(1, 8'hA5, PAR_EVEN, 1'b0, 48);
    for (int k = 0; k < 44; k++) begin
      checks++; if (cap_tx[k] !== e[k/4]) begin errors++; $display("FAIL a5_tx k=%0d got %b exp %b", k, cap_tx[k], e[k/4]); end
    end
    for (int k = 0; k <= 48; k++) begin
      checks++; if (cap_done[k] !== (k == 44)) begin errors++; $display("FAIL a5_done k=%0d got %b exp %b", k, cap_done[k], (k == 44)); end
      checks++; if (cap_rdy[k] !== (k >= 44)) begin errors++; $display("FAIL a5_ready k=%0d got %b exp %b", k, cap_rdy[k], (k >= 44)); end
    end
`ifdef TX_FRAMER_FRAME_OUT_EN
    checks++; if (f1 !== 11'b0_10100101_0_1) begin errors++; $display("FAIL a5_frame got %b exp 01010010101", f1); end
`endif
  endtask

  task automatic test_parity_07();
    logic [1:0]  modes [0:1];
    logic [0:10] exps  [0:1];
    modes[0] = PAR_ODD;  exps[0] = 11'b01110000001;
    modes[1] = PAR_EVEN; exps[1] = 11'b01110000011;
    for (int c = 0; c < 2; c++) begin
      capture(1, 8'h07, modes[c], 1'b0, 48);
      for (int k = 0; k < 44; k++) begin
        checks++; if (cap_tx[k] !== exps[c][k/4]) begin errors++; $display("FAIL p07_tx mode=%b k=%0d got %b exp %b", modes[c], k, cap_tx[k], exps[c][k/4]); end
      end
      checks++; if (cap_done[44] !== 1'b1) begin errors++; $display("FAIL p07_done mode=%b got %b exp 1", modes[c], cap_done[44]); end
    end
  endtask

  task automatic test_no_parity();
    logic [0:10] e2;
    logic [0:9]  e1;
    e2 = 11'b01111111111;
    capture(2, 8'hFF, 2'b11, 1'b0, 52);
    for (int k = 0; k < 44; k++) begin
      checks++; if (cap_tx[k] !== e2[k/4]) begin errors++; $display("FAIL ff_stop2_tx k=%0d got %b exp %b", k, cap_tx[k], e2[k/4]); end
    end
    for (int k = 0; k <= 52; k++) begin
      checks++; if (cap_done[k] !== (k == 44)) begin errors++; $display("FAIL ff_stop2_done k=%0d got %b exp %b", k, cap_done[k], (k == 44)); end
    end
    e1 = 10'b0001111001;
    capture(1, 8'h3C, PAR_NONE, 1'b0, 44);
    for (int k = 0; k < 40; k++) begin
      checks++; if (cap_tx[k] !== e1[k/4]) begin errors++; $display("FAIL 3c_none_tx k=%0d got %b exp %b", k, cap_tx[k], e1[k/4]); end
    end
    for (int k = 0; k <= 44; k++) begin
      checks++; if (cap_done[k] !== (k == 40)) begin errors++; $display("FAIL 3c_none_done k=%0d got %b exp %b", k, cap_done[k], (k == 40)); end
    end
  endtask

  task automatic test_data_w5();
    logic [0:7] e;
    e = 8'b01100111;
    capture(3, 8'h13, PAR_EVEN, 1'b0, 36);
    for (int k = 0; k < 32; k++) begin
      checks++; if (cap_tx[k] !== e[k/4]) begin errors++; $display("FAIL w5_tx k=%0d got %b exp %b", k, cap_tx[k], e[k/4]); end
    end
    for (int k = 0; k <= 36; k++) begin
      checks++; if (cap_done[k] !== (k == 32)) begin errors++; $display("FAIL w5_done k=%0d got %b exp %b", k, cap_done[k], (k == 32)); end
    end
`ifdef TX_FRAMER_FRAME_OUT_EN
    checks++; if (f3 !== 9'b0_10011_1_1) begin errors++; $display("FAIL w5_frame got %b exp 010011111", f3); end
`endif
  endtask

  task automatic test_tick_on_accept();
    logic [0:10] e;
    e = 11'b01000000101;
    capture(1, 8'h81, PAR_EVEN, 1'b1, 48);
    for (int k = 0; k < 44; k++) begin
      checks++; if (cap_tx[k] !== e[k/4]) begin errors++; $display("FAIL acc_tick_tx k=%0d got %b exp %b", k, cap_tx[k], e[k/4]); end
    end
    checks++; if (cap_done[44] !== 1'b1) begin errors++; $display("FAIL acc_tick_done got %b exp 1", cap_done[44]); end
  endtask

  task automatic test_reset_mid_frame();
    int ndone;
    ndone = 0;
    data8 = 8'hA5; par = PAR_EVEN; v1 = 1'b1;
    step();
    v1 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick = ((k % 4) == 0);
      step();
      if (d1) ndone++;
    end
    tick = 1'b0;
    checks++; if (t1 !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx got %b exp 0", t1); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (t1 !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", t1); end
    checks++; if (r1 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", r1); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", b1); end
    for (int k = 0; k < 3; k++) begin
      tick = ~tick;
      step();
      if (d1) ndone++;
      checks++; if (t1 !== 1'b1) begin errors++; $display("FAIL midrst_hold_tx k=%0d got %b exp 1", k, t1); end
    end
    tick = 1'b0;
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", ndone); end
    step();
    rst = 1'b0;
    data8 = 8'h81; par = PAR_EVEN; v1 = 1'b1;
    step();
    v1 = 1'b0;
    checks++; if (b1 !== 1'b1 || t1 !== 1'b0) begin errors++; $display("FAIL first_accept got busy=%b tx=%b exp busy=1 tx=0", b1, t1); end
    ndone = 0;
    for (int k = 1; k <= 48; k++) begin
      tick = ((k % 4) == 0);
      step();
      if (d1) ndone++;
    end
    tick = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL post_rst_done_count got %0d exp 1", ndone); end
    $display("reset mid-frame and restart complete");
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [0:2];
    logic       exp_par [0:2];
    logic       bits [0:15];
    logic [7:0] got;
    logic       rb, tb;
    int nb, nacc, nfr, cyc;
    words[0] = 8'h3C; exp_par[0] = 1'b0;
    words[1] = 8'h01; exp_par[1] = 1'b1;
    words[2] = 8'h7F; exp_par[2] = 1'b1;
    nb = 0; nacc = 0; nfr = 0;
    tick = 1'b0; par = PAR_EVEN; data8 = words[0]; v1 = 1'b1;
    for (cyc = 0; cyc < 400 && nfr < 3; cyc++) begin
      rb = r1; tb = tick;
      step();
      if (rb && v1) begin
        nacc++;
        nb = 0;
        bits[0] = t1;
        nb = 1;
      end else if (tb && b1 && nb < 16) begin
        bits[nb] = t1;
        nb++;
      end
      if (d1) begin
        got = '0;
        for (int i = 0; i < 8; i++) got[i] = bits[1 + i];
        checks++; if (nb !== 11) begin errors++; $display("FAIL b2b_bitcount frame=%0d got %0d exp 11", nfr, nb); end
        checks++; if (bits[0] !== 1'b0 || bits[10] !== 1'b1) begin errors++; $display("FAIL b2b_framing frame=%0d got start=%b stop=%b exp 0/1", nfr, bits[0], bits[10]); end
        checks++; if (got !== words[nfr]) begin errors++; $display("FAIL b2b_data frame=%0d got %h exp %h", nfr, got, words[nfr]); end
        checks++; if (bits[9] !== exp_par[nfr]) begin errors++; $display("FAIL b2b_parity frame=%0d got %b exp %b", nfr, bits[9], exp_par[nfr]); end
        checks++; if (r1 !== 1'b1 || t1 !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap frame=%0d got ready=%b tx=%b exp 1/1", nfr, r1, t1); end
        $display("b2b frame=%0d data=%h parity=%b", nfr, got, bits[9]);
        nfr++;
      end
      tick = ((cyc % 4) == 3);
      if (r1) begin
        if (nacc < 3) begin
          data8 = words[nacc]; par = PAR_EVEN; v1 = 1'b1;
        end else begin
          v1 = 1'b0;
        end
      end else begin
        data8 = 8'($urandom);
        par   = 2'($urandom);
      end
    end
    v1 = 1'b0; tick = 1'b0;
    checks++; if (nfr !== 3) begin errors++; $display("FAIL b2b_frames got %0d exp 3 within %0d cycles", nfr, cyc); end
    checks++; if (nacc !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", nacc); end
  endtask

  initial begin
    test_reset();
    test_frame_even_a5();
    test_parity_07();
    test_no_parity();
    test_data_w5();
    test_tick_on_accept();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
